// File: rtl/ps2_rx_frontend_pkg.sv
// Shared PS/2 receive definitions: frame FSM encoding, prefix bytes and frame geometry.
// Also used by the downstream keyboard register stage.
package ps2_rx_frontend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int PS2_FRAME_LEN = 11;
    localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

    // Parity bit that makes the 9-bit {parity, data} group contain an odd number of ones.
    function automatic logic odd_parity_bit(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronisers for the PS/2 clock and data pins plus a FILTER_LEN-sample
// deglitcher on the clock; emits the synced data bit and a one-cycle filtered-fall pulse.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_data,
    output logic o_fall
);

    localparam int CNT_W = $clog2(FILTER_LEN);

    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    logic w_sample;
    logic w_differs;
    logic w_flip;

    assign w_sample  = r_clk_sync[1];
    assign w_differs = (w_sample != r_filt);
    // r_cnt counts consecutive samples disagreeing with r_filt; the FILTER_LEN-th one flips it.
    assign w_flip    = w_differs && (r_cnt == CNT_W'(FILTER_LEN - 1));

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt      <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            if (!w_differs || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_flip) begin
                r_filt <= w_sample;
            end
        end
    end

    assign o_fall = w_flip && r_filt;
    assign o_data = r_data_sync[1];

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 receive front end: frame deserialiser with start/parity/stop/timeout checks and
// E0/F0 prefix folding. Optional err_count output enabled by `define PS2_RX_ERR_COUNT_EN.
module ps2_rx_frontend
    import ps2_rx_frontend_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_error
`ifdef PS2_RX_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    ps2_state_e r_state;
    ps2_state_e w_next_state;

    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_par_err;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext_pend;
    logic            r_brk_pend;
    logic [7:0]      r_scancode;
    logic            r_valid;
    logic            r_is_brk;
    logic            r_is_ext;
    logic            r_frame_error;

    logic w_fall;
    logic w_data;
    logic w_to_hit;
    logic w_accept;
    logic w_err_det;
    logic w_is_prefix;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk        (system_clk),
        .rst_n      (reset),
        .i_ps2_clk  (PS2_clk),
        .i_ps2_data (PS2_data),
        .o_data     (w_data),
        .o_fall     (w_fall)
    );

    // Terminal count inside a frame; a simultaneous fall event takes priority over it.
    assign w_to_hit    = (r_state != ST_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_is_prefix = (r_shift == PS2_PREFIX_EXT) || (r_shift == PS2_PREFIX_BRK);

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first so no path through the block leaves a latch.
    always_comb begin
        w_next_state = r_state;
        if (w_fall) begin
            unique case (r_state)
                ST_IDLE:   if (!w_data) w_next_state = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) w_next_state = ST_PARITY;
                ST_PARITY: w_next_state = ST_STOP;
                ST_STOP:   w_next_state = ST_IDLE;
            endcase
        end else if (w_to_hit) begin
            w_next_state = ST_IDLE;
        end
    end

    always_comb begin
        w_accept  = 1'b0;
        w_err_det = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                ST_IDLE: w_err_det = w_data;
                ST_STOP: begin
                    w_accept  = w_data && !r_par_err;
                    w_err_det = !(w_data && !r_par_err);
                end
                default: ;
            endcase
        end else if (w_to_hit) begin
            w_err_det = 1'b1;
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_fall) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (!w_data) begin
                            r_bit_cnt <= '0;
                            r_par_err <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_par_err <= (w_data != odd_parity_bit(r_shift));
                    ST_STOP:   ;
                endcase
            end
            if ((r_state == ST_IDLE) || w_fall || w_to_hit) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_ext_pend    <= 1'b0;
            r_brk_pend    <= 1'b0;
            r_scancode    <= 8'h00;
            r_valid       <= 1'b0;
            r_is_brk      <= 1'b0;
            r_is_ext      <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_valid       <= w_accept && !w_is_prefix;
            r_frame_error <= w_err_det;
            if (w_err_det) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (w_accept) begin
                if (r_shift == PS2_PREFIX_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == PS2_PREFIX_BRK) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_scancode <= r_shift;
                    r_is_ext   <= r_ext_pend;
                    r_is_brk   <= r_brk_pend;
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end
            end
        end
    end

    assign scancode       = r_scancode;
    assign scancode_valid = r_valid;
    assign is_break       = r_is_brk;
    assign is_extended    = r_is_ext;
    assign frame_error    = r_frame_error;

`ifdef PS2_RX_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= 8'h00;
        end else if (r_frame_error && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Scoreboard bench for ps2_rx_frontend: PS/2 frames are bit-banged onto the pins, expected
// strobes are queued by a reference model and matched as the DUT emits them.
module tb_ps2_rx_frontend;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 400;
    localparam int HALF           = 20;

    logic       system_clk = 1'b0;
    logic       reset      = 1'b0;
    logic       PS2_clk    = 1'b1;
    logic       PS2_data   = 1'b1;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_error;
`ifdef PS2_RX_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    always #5 system_clk = ~system_clk;

    ps2_rx_frontend #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .system_clk     (system_clk),
        .reset          (reset),
        .PS2_clk        (PS2_clk),
        .PS2_data       (PS2_data),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .is_break       (is_break),
        .is_extended    (is_extended),
        .frame_error    (frame_error)
`ifdef PS2_RX_ERR_COUNT_EN
        ,
        .err_count      (err_count)
`endif
    );

    typedef enum {LAT_NONE, LAT_EXACT, LAT_TIMEOUT} lat_e;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        lat_e       lat;
    } exp_t;

    exp_t sb[$];

    int   n_vec         = 0;
    int   n_miss        = 0;
    int   cyc           = 0;
    int   last_fall_cyc = 0;
    logic m_ext         = 1'b0;
    logic m_brk         = 1'b0;
    int   m_err_total   = 0;

    task automatic push_exp(input bit is_err, input logic [7:0] code, input logic brk,
                            input logic ext, input lat_e lat);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.brk    = brk;
        e.ext    = ext;
        e.lat    = lat;
        sb.push_back(e);
    endtask

    task automatic expect_error(input lat_e lat);
        push_exp(1'b1, 8'h00, 1'b0, 1'b0, lat);
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_err_total++;
    endtask

    // Called once per cycle on the falling edge, away from the DUT's active edge.
    task automatic monitor();
        exp_t e;
        int   dt;
        if (scancode_valid === 1'b1 && frame_error === 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL both_strobes cyc=%0d valid=1 frame_error=1 required=never together", cyc);
        end
        if (scancode_valid === 1'b1 || frame_error === 1'b1) begin
            dt = cyc - last_fall_cyc;
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_strobe cyc=%0d valid=%b err=%b code=%h required=no event",
                         cyc, scancode_valid, frame_error, scancode);
            end else begin
                e = sb.pop_front();
                if (e.is_err) begin
                    if (frame_error !== 1'b1) begin
                        n_miss++;
                        $display("FAIL event_kind cyc=%0d got scancode %h, required frame_error",
                                 cyc, scancode);
                    end
                end else begin
                    if ({scancode_valid, scancode, is_break, is_extended} !==
                        {1'b1, e.code, e.brk, e.ext}) begin
                        n_miss++;
                        $display("FAIL scancode_event cyc=%0d got v=%b code=%h brk=%b ext=%b, required v=1 code=%h brk=%b ext=%b",
                                 cyc, scancode_valid, scancode, is_break, is_extended, e.code, e.brk, e.ext);
                    end
                end
                if (e.lat == LAT_EXACT) begin
                    n_vec++;
                    if (dt != FILTER_LEN + 2) begin
                        n_miss++;
                        $display("FAIL strobe_latency got %0d cycles after fall drive, required %0d",
                                 dt, FILTER_LEN + 2);
                    end
                end else if (e.lat == LAT_TIMEOUT) begin
                    n_vec++;
                    if (dt < TIMEOUT_CYCLES || dt > TIMEOUT_CYCLES + FILTER_LEN + 4) begin
                        n_miss++;
                        $display("FAIL timeout_latency got %0d cycles after last fall, required %0d..%0d",
                                 dt, TIMEOUT_CYCLES, TIMEOUT_CYCLES + FILTER_LEN + 4);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge system_clk);
        monitor();
        @(posedge system_clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic ps2_bit(input logic b);
        PS2_data = b;
        ticks(HALF);
        PS2_clk       = 1'b0;
        last_fall_cyc = cyc;
        ticks(HALF);
        PS2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        if (bad_par) begin
            expect_error(LAT_EXACT);
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            push_exp(1'b0, b, m_brk, m_ext, LAT_EXACT);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL %s_missing_events got %0d outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic [7:0] code_req);
        n_vec++;
        if ({scancode, scancode_valid, is_break, is_extended, frame_error} !==
            {code_req, 4'b0000}) begin
            n_miss++;
            $display("FAIL %s got code=%h v=%b brk=%b ext=%b err=%b, required code=%h v=0 brk=0 ext=0 err=0",
                     name, scancode, scancode_valid, is_break, is_extended, frame_error, code_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ticks(4);
        check_idle_outputs("reset_values", 8'h00);
`ifdef PS2_RX_ERR_COUNT_EN
        n_vec++;
        if (err_count !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_err_count got %h, required 00", err_count);
        end
`endif
        reset = 1'b1;
        ticks(5);
    endtask

    task automatic test_single_frame();
        send_frame(8'h1C, 1'b0);
        drain("single_frame");
        check_idle_outputs("hold_after_strobe", 8'h1C);
    endtask

    task automatic test_break_prefix();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain("break_prefix");
    endtask

    task automatic test_extended_break();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h74, 1'b0);
        drain("extended_break");
    endtask

    task automatic test_parity_error();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h29, 1'b0);
        drain("parity_error");
    endtask

    task automatic test_idle_error();
        send_frame(8'hF0, 1'b0);
        expect_error(LAT_EXACT);
        ps2_bit(1'b1);
        send_frame(8'h1C, 1'b0);
        drain("idle_error");
    endtask

    task automatic test_timeout();
        logic [4:0] partial;
        partial = 5'b10110;
        send_frame(8'hE0, 1'b0);
        expect_error(LAT_TIMEOUT);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(partial[i]);
        PS2_data = 1'b1;
        ticks(TIMEOUT_CYCLES + 10);
        send_frame(8'h45, 1'b0);
        drain("timeout");
    endtask

    task automatic test_glitch_and_reset();
        PS2_data = 1'b1;
        PS2_clk  = 1'b0;
        ticks(3);
        PS2_clk = 1'b1;
        ticks(30);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        reset = 1'b0;
        ticks(4);
        check_idle_outputs("mid_frame_reset", 8'h00);
        reset = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        ticks(5);
        send_frame(8'h16, 1'b0);
        drain("glitch_and_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, 1'b0);
        end
        send_frame(8'h5A, 1'b0);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_break_prefix();
        test_extended_break();
        test_parity_error();
        test_idle_error();
        test_timeout();
        test_back_to_back();
        test_glitch_and_reset();
`ifdef PS2_RX_ERR_COUNT_EN
        n_vec++;
        if (err_count !== 8'((m_err_total > 255) ? 255 : m_err_total)) begin
            n_miss++;
            $display("FAIL err_count got %0d, required %0d", err_count, m_err_total);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frontend.md
Name: ps2_rx_frontend

Overview:
Upstream stage of the memory-mapped keyboard peripheral. Synchronises the raw PS/2 clock and data lines into the system_clk domain and deglitches the PS/2 clock. Deserialises 11-bit frames and checks start, parity and stop bits, with a timeout on stalled frames. Folds E0/F0 prefix bytes into flags and presents one scancode per key event to the ASCII/register stage as a single-cycle strobe.

Parameters:
FILTER_LEN, 8, number of consecutive equal synchronised PS2_clk samples required to change the filtered clock level (min 2).
TIMEOUT_CYCLES, 50000, system_clk cycles allowed between PS/2 falling edges inside a frame before it is aborted (1 ms at 50 MHz).

Ports:
system_clk  input  1  system clock; the only clock in the block.
reset  input  1  asynchronous, active-low reset (0 = reset).
PS2_clk  input  1  raw PS/2 clock from the pin, asynchronous.
PS2_data  input  1  raw PS/2 data from the pin, asynchronous.
scancode  output  8  last completed non-prefix scancode byte.
scancode_valid  output  1  one-cycle strobe; scancode and the flags are valid in this cycle.
is_break  output  1  an F0 prefix preceded this scancode (key release).
is_extended  output  1  an E0 prefix preceded this scancode.
frame_error  output  1  one-cycle strobe on a framing, parity or timeout error.

Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: scancode=8'h00, scancode_valid=0, is_break=0, is_extended=0, frame_error=0.
- Reset also clears: FSM to IDLE, bit counter, prefix flags, timeout counter, and filter to all-ones (idle-high).
- Synchronisers: PS2_clk and PS2_data each pass through 2 flops.
- Clock filter:
  - Filtered clock goes 0 after FILTER_LEN consecutive 0 samples.
  - It goes 1 after FILTER_LEN consecutive 1 samples.
  - Otherwise it holds its level.
  - A "fall" event is a 1->0 transition of the filtered clock. Synchronised PS2_data is sampled in the same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on fall events, except timeout.
  - IDLE: sampled 0 -> DATA and clear the bit counter. Sampled 1 -> stay in IDLE and pulse frame_error.
  - DATA: shift the sampled bit into the byte LSB-first. After the 8th bit -> PARITY.
  - PARITY: the sampled bit must equal ~^byte (odd parity over 9 bits). Either way -> STOP; on mismatch, latch a parity-error flag.
  - STOP: sampled 1 with no parity error -> accept the byte. Otherwise pulse frame_error. Always -> IDLE.
- Accepted byte handling:
  - 8'hE0: set the pending extended flag. No strobe.
  - 8'hF0: set the pending break flag. No strobe.
  - Any other byte: in the next cycle, drive scancode=byte, is_extended/is_break from the pending flags, and pulse scancode_valid for 1 cycle. Then clear the pending flags.
- Latency: scancode_valid rises exactly 1 system_clk cycle after the cycle that detects the stop-bit fall event.
- Output holding: scancode, is_break and is_extended hold their values until the next strobe.
- Timeout:
  - In DATA, PARITY or STOP, a counter increments each cycle and resets on every fall event.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, clear the pending flags.
- Any frame_error also clears the pending prefix flags.
- frame_error and scancode_valid are never high in the same cycle.
- A fall event coinciding with the timeout terminal count: the fall event wins and the counter resets.
- Back-to-back frames need no idle gap: a start bit is accepted on the first fall event after STOP.

Optional Feature:
Macro PS2_RX_ERR_COUNT_EN.
- Defined: adds output err_count [7:0]. It resets to 0, increments on each frame_error pulse, and saturates at 8'hFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared header ps2_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3).
  - Prefix constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
  - Frame length 11.
- The downstream keyboard register stage uses the same header.
- One sub-module, ps2_line_filter: 2-flop synchronisers plus the FILTER_LEN deglitcher. It outputs the synced data bit and a one-cycle fall pulse.
- The frame FSM and prefix logic stay in the top module.

Test Plan:
1. Frame 0x1C: start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1 -> one scancode_valid with scancode=8'h1C, is_break=0, is_extended=0, one cycle after the stop fall.
2. Frames F0 then 1C -> no strobe after F0; one strobe with scancode=8'h1C, is_break=1. A following 1C frame gives is_break=0.
3. Frames E0, F0, 74 -> a single strobe with scancode=8'h74, is_extended=1, is_break=1.
4. Frame 0x1C with parity bit 1 -> frame_error pulse, no scancode_valid, and pending flags cleared. A following 0x29 frame -> scancode=8'h29.
5. Start bit plus 5 data bits, then PS2_clk held high for TIMEOUT_CYCLES+10 cycles -> one frame_error pulse and FSM back in IDLE. A following 0x45 frame decodes correctly.
6. 3-cycle low glitch on PS2_clk (FILTER_LEN=8) -> no bit consumed. Reset asserted after 4 data bits, then released, then a 0x16 frame -> scancode=8'h16 with no error.
